cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Test-run sequencer for cpu_top.
- Streams a program image into the instruction memory write port while the CPU is held in reset, then releases the CPU.
- Watches the fetch PC for the pass signature: a transition from last_addr to pass_addr.
- Reports pass, timeout and cycle count.
- Replaces the behavioural PC monitor with synthesizable control usable on FPGA and in regression.

Parameters:
IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; AW = $clog2(IMEM_DEPTH)
MAX_CYCLES, 2000, RUN cycles before timeout
RST_HOLD, 4, cycles cpu_rst_n stays low after load completes (1..15)
CNT_W, 32, width of cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins load+run; honoured only in IDLE or DONE
ld_valid  in  1  loader word valid
ld_ready  out  1  loader word accepted when valid&ready
ld_data  in  32  instruction word
ld_last  in  1  final word of image, qualified by valid&ready
imem_we  out  1  instruction memory write enable
imem_waddr  out  AW  word address
imem_wdata  out  32  write data
cpu_rst_n  out  1  active-low reset to cpu_top
pc_current  in  32  cpu_top pc_current_s1
pass_addr  in  32  pass PC; stable from start until DONE
last_addr  in  32  required predecessor PC
last_addr_vld  in  1  0 = fallback: arrival at pass_addr alone passes
busy  out  1  state is LOAD, RELEASE or RUN
done  out  1  state is DONE
pass  out  1  run ended on pass signature
timeout  out  1  run ended on MAX_CYCLES
cycles  out  CNT_W  RUN cycles counted, including the terminating cycle

Behaviour:
- Reset values: state=IDLE; ld_ready=0; imem_we=0; imem_waddr=0; imem_wdata=0; cpu_rst_n=0; busy=0; done=0; pass=0; timeout=0; cycles=0.
- Reset mid-operation aborts any load or run and forces the CPU back into reset on the same edge.
- FSM states: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE:
  - cpu_rst_n=0.
  - On start: clear pass/timeout/cycles/waddr and go to LOAD.
- LOAD:
  - ld_ready=1, cpu_rst_n=0.
  - Each valid&ready writes in the same cycle: imem_we=1 (combinational from handshake), imem_waddr=current address, imem_wdata=ld_data. The address then increments.
  - Go to RELEASE on handshake with ld_last=1.
  - Also go to RELEASE on handshake at address IMEM_DEPTH-1, which is treated as an implicit last. No wrap-around ever occurs.
  - ld_valid low stalls LOAD indefinitely; no timeout applies in LOAD.
- RELEASE:
  - cpu_rst_n=0 and ld_ready=0 for exactly RST_HOLD cycles, counted by an internal hold counter.
  - Then go to RUN.
- RUN:
  - cpu_rst_n=1.
  - cycles increments every RUN cycle.
  - prev_pc registers pc_current each cycle. prev_vld is 0 in the first RUN cycle and 1 thereafter.
  - Pass condition: pc_current==pass_addr && (!last_addr_vld || (prev_vld && prev_pc==last_addr)).
  - On pass: pass=1, go to DONE. cycles reports the count including that cycle; the first RUN cycle counts as 1.
  - Timeout: if the cycles value after increment equals MAX_CYCLES and pass is not met, set timeout=1 and go to DONE.
  - Pass and timeout in the same cycle: pass wins and timeout stays 0.
- DONE:
  - cpu_rst_n=0 (CPU halted); pass/timeout/cycles held.
  - start re-enters LOAD with results cleared.
- start in LOAD/RELEASE/RUN is ignored.
- start coincident with rst: rst wins.
- pass and timeout are mutually exclusive and change only on entry to DONE or when cleared by start.

Optional Feature:
RUN_CTRL_FAIL_DET_EN
- Defined: adds input fail_addr (32) and output fail (1, reset 0).
  - In RUN, pc_current==fail_addr sets fail=1 and enters DONE.
  - Priority: pass > fail > timeout.
  - fail is cleared by start.
- Undefined: neither port exists; runs end only on pass or timeout.

Test Plan:
- Load 4 words (ld_last on 4th, valid held high):
  - imem writes go to addresses 0..3 on 4 consecutive cycles.
  - Then cpu_rst_n stays low for 4 cycles before RUN.
- Stub PC sequence 0x4E8, 0x4EC, 0x504 with pass_addr=0x504, last_addr=0x4EC, last_addr_vld=1:
  - pass=1, done=1, cycles=3, cpu_rst_n=0 in DONE.
- PC jumps 0x500 -> 0x504 with last_addr_vld=1 (wrong predecessor) and PC then stuck:
  - no pass; timeout=1 with cycles=2000.
  - Same stimulus with last_addr_vld=0: pass with cycles=2.
- pass_addr reached exactly on cycle 2000:
  - pass=1, timeout=0.
- Stream 1030 words with no ld_last into IMEM_DEPTH=1024:
  - last write at address 1023, then RELEASE.
  - ld_ready=0 afterwards; no wrap to address 0.
- Assert rst during RUN at cycle 50:
  - next edge: all outputs at reset values, state IDLE.
  - start then reruns cleanly with cycles counting from 1.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Test-run sequencer: streams a program image into IMEM, releases the CPU, watches for the pass PC signature.
// Optional macro RUN_CTRL_FAIL_DET_EN adds fail_addr/fail detection (priority pass > fail > timeout).
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 1024,
  parameter int MAX_CYCLES = 2000,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 32,
  localparam int AW        = $clog2(IMEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst_n,
  input  logic [31:0]      pc_current,
  input  logic [31:0]      pass_addr,
  input  logic [31:0]      last_addr,
  input  logic             last_addr_vld,
`ifdef RUN_CTRL_FAIL_DET_EN
  input  logic [31:0]      fail_addr,
  output logic             fail,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [31:0]      prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             fail_q, fail_d;
  logic             ld_hs;
  logic             pass_hit;
  logic             fail_hit;
  logic [CNT_W-1:0] cycles_inc;

  assign ld_ready   = (state_q == S_LOAD);
  assign ld_hs      = ld_valid && ld_ready;
  assign imem_we    = ld_hs;
  assign imem_waddr = waddr_q;
  assign imem_wdata = ld_hs ? ld_data : 32'd0;
  assign cpu_rst_n  = (state_q == S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign cycles_inc = cycles_q + CNT_W'(1);

  // Without a valid predecessor address, arriving at pass_addr alone is the signature.
  assign pass_hit = (pc_current == pass_addr) &&
                    (!last_addr_vld || (prev_vld_q && (prev_pc_q == last_addr)));

`ifdef RUN_CTRL_FAIL_DET_EN
  assign fail_hit = (pc_current == fail_addr);
  assign fail     = fail_q;
`else
  assign fail_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    hold_d     = hold_q;
    cycles_d   = cycles_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    fail_d     = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          waddr_d   = '0;
          cycles_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fail_d    = 1'b0;
        end
      end
      S_LOAD: begin
        // The top address is an implicit last word, so the address never wraps.
        if (ld_hs) begin
          if (ld_last || (waddr_q == AW'(IMEM_DEPTH - 1))) begin
            state_d = S_RELEASE;
            hold_d  = '0;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      S_RELEASE: begin
        prev_vld_d = 1'b0;
        if (hold_q == 4'(RST_HOLD - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_RUN: begin
        cycles_d   = cycles_inc;
        prev_pc_d  = pc_current;
        prev_vld_d = 1'b1;
        if (pass_hit) begin
          pass_d  = 1'b1;
          state_d = S_DONE;
        end else if (fail_hit) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else if (cycles_inc == CNT_W'(MAX_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      hold_q     <= '0;
      cycles_q   <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      hold_q     <= hold_d;
      cycles_q   <= cycles_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_q     <= fail_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed test-plan steps plus randomized runs
// compared against a behavioural model of the load and pass/timeout rules.
module tb_cpu_run_ctrl;

  localparam int IMEM_DEPTH = 1024;
  localparam int MAX_CYCLES = 2000;
  localparam int RST_HOLD   = 4;
  localparam int CNT_W      = 32;
  localparam int AW         = $clog2(IMEM_DEPTH);

  logic             clk;
  logic             rst;
  logic             start;
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_data;
  logic             ld_last;
  logic             imem_we;
  logic [AW-1:0]    imem_waddr;
  logic [31:0]      imem_wdata;
  logic             cpu_rst_n;
  logic [31:0]      pc_current;
  logic [31:0]      pass_a;
  logic [31:0]      last_a;
  logic             last_vld;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] cycles;
`ifdef RUN_CTRL_FAIL_DET_EN
  logic             fail;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] pc_seq[$];

  cpu_run_ctrl #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .MAX_CYCLES(MAX_CYCLES),
    .RST_HOLD  (RST_HOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .pc_current   (pc_current),
    .pass_addr    (pass_a),
    .last_addr    (last_a),
    .last_addr_vld(last_vld),
`ifdef RUN_CTRL_FAIL_DET_EN
    .fail_addr    (32'hFFFF_FFFC),
    .fail         (fail),
`endif
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .cycles       (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ld_ready"}, ld_ready, 0);
    checkOutput({tag, "_imem_we"}, imem_we, 0);
    checkOutput({tag, "_imem_waddr"}, imem_waddr, 0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
    checkOutput({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_cycles"}, cycles, 0);
  endtask

  // Reference: walk the PC stream cycle by cycle, the PC sticks at its final value.
  function automatic void modelRun(output bit p, output bit t, output int c);
    int n;
    logic [31:0] cur;
    logic [31:0] prev;
    n = pc_seq.size();
    p = 1'b0;
    t = 1'b0;
    c = 0;
    for (int i = 1; i <= MAX_CYCLES; i++) begin
      cur  = pc_seq[(i - 1 < n) ? i - 1 : n - 1];
      prev = (i > 1) ? pc_seq[(i - 2 < n) ? i - 2 : n - 1] : 32'd0;
      if (cur == pass_a && (!last_vld || (i > 1 && prev == last_a))) begin
        p = 1'b1;
        c = i;
        return;
      end
      if (i == MAX_CYCLES) begin
        t = 1'b1;
        c = i;
        return;
      end
    end
  endfunction

  // Start pulse; called and returning on a falling edge.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_pass_clr", pass, 0);
    checkOutput("start_cycles_clr", cycles, 0);
  endtask

  task automatic loadImage(input int n, input bit use_last, input bit gaps);
    int exp_addr = 0;
    int sent = 0;
    int guard = 0;
    bit fin = 1'b0;
    logic [31:0] word;
    while (!fin && guard < 4 * n + 20) begin
      word     = $urandom;
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = word;
      ld_last  = use_last && (sent == n - 1);
      #1;
      checkOutput("ld_ready", ld_ready, 1);
      checkOutput("imem_we", imem_we, ld_valid);
      if (ld_valid) begin
        checkOutput("imem_waddr", imem_waddr, exp_addr);
        checkOutput("imem_wdata", imem_wdata, word);
        sent++;
        exp_addr++;
        fin = ld_last || (exp_addr == IMEM_DEPTH);
      end
      guard++;
      @(negedge clk);
    end
    ld_last = 1'b0;
    checkOutput("load_finished", fin, 1);
  endtask

  task automatic checkRelease(input bit keep_valid);
    int hold = 0;
    ld_valid = keep_valid;
    #1;
    while (cpu_rst_n !== 1'b1 && hold < 40) begin
      checkOutput("rel_ld_ready", ld_ready, 0);
      checkOutput("rel_imem_we", imem_we, 0);
      hold++;
      @(negedge clk);
      #1;
    end
    ld_valid = 1'b0;
    checkOutput("rst_hold", hold, RST_HOLD);
    checkOutput("run_busy", busy, 1);
  endtask

  task automatic runPc(input int abort_at, input bit poke);
    int k = 0;
    int n = pc_seq.size();
    bit ep;
    bit et;
    int ec;
    while (done !== 1'b1 && k < MAX_CYCLES + 20) begin
      if (abort_at != 0 && k == abort_at) begin
        checkOutput("pre_abort_cycles", cycles, abort_at);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("abort");
        return;
      end
      pc_current = pc_seq[(k < n) ? k : n - 1];
      start = poke && (k == 5);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("run_done", done, 1);
    modelRun(ep, et, ec);
    checkOutput("pass", pass, ep);
    checkOutput("timeout", timeout, et);
    checkOutput("cycles", cycles, ec);
    checkOutput("done_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("done_busy", busy, 0);
  endtask

  task automatic setRun(input logic [31:0] pa, input logic [31:0] la, input logic lv);
    pass_a   = pa;
    last_a   = la;
    last_vld = lv;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    pc_current = '0;
    setRun(32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    // 4-word image then the predecessor-qualified pass signature
    applyStimulus();
    loadImage(4, 1'b1, 1'b0);
    checkRelease(1'b0);
    pc_seq = '{32'h4E8, 32'h4EC, 32'h504};
    setRun(32'h504, 32'h4EC, 1'b1);
    runPc(0, 1'b0);

    // Wrong predecessor then stuck PC: timeout; a stray start mid-run is ignored
    applyStimulus();
    loadImage(2, 1'b1, 1'b0);
    checkRelease(1'b0);
    pc_seq = '{32'h500, 32'h504};
    setRun(32'h504, 32'h4EC, 1'b1);
    runPc(0, 1'b1);

    applyStimulus();
    loadImage(2, 1'b1, 1'b0);
    checkRelease(1'b0);
    setRun(32'h504, 32'h4EC, 1'b0);
    runPc(0, 1'b0);

    // Pass arrives on exactly the timeout cycle
    applyStimulus();
    loadImage(1, 1'b1, 1'b0);
    checkRelease(1'b0);
    pc_seq = {};
    for (int i = 0; i < MAX_CYCLES - 1; i++) pc_seq.push_back(32'h100);
    pc_seq.push_back(32'h200);
    setRun(32'h200, 32'h0, 1'b0);
    runPc(0, 1'b0);

    // Oversized image without ld_last stops at the top address
    applyStimulus();
    loadImage(1030, 1'b0, 1'b0);
    checkRelease(1'b1);
    pc_seq = '{32'h0};
    setRun(32'h0, 32'h0, 1'b0);
    runPc(0, 1'b0);

    // Reset at RUN cycle 50, then a clean rerun
    applyStimulus();
    loadImage(3, 1'b1, 1'b0);
    checkRelease(1'b0);
    pc_seq = '{32'h40};
    setRun(32'h80, 32'h0, 1'b0);
    runPc(50, 1'b0);
    applyStimulus();
    loadImage(3, 1'b1, 1'b0);
    checkRelease(1'b0);
    pc_seq = '{32'h40, 32'h44, 32'h80};
    runPc(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      applyStimulus();
      loadImage($urandom_range(1, 20), 1'b1, 1'b1);
      checkRelease(1'b0);
      pc_seq = {};
      for (int i = 0; i < $urandom_range(1, 8); i++)
        pc_seq.push_back(32'h10 + 32'($urandom_range(0, 3)) * 4);
      setRun(32'h10 + 32'($urandom_range(0, 3)) * 4,
             32'h10 + 32'($urandom_range(0, 3)) * 4,
             1'($urandom_range(0, 1)));
      runPc(0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
